// File: rtl/saber_pkg.sv
// Snapshot types for the saber pose history.
// Each snapshot holds four endpoints, and each endpoint is a packed x/y/z coordinate.
package saber_pkg;

    localparam int COORD_XY_W = 12;
    localparam int COORD_Z_W  = 14;

    typedef struct packed {
        logic [COORD_XY_W-1:0] x;
        logic [COORD_XY_W-1:0] y;
        logic [COORD_Z_W-1:0]  z;
    } endpoint_t;

    typedef struct packed {
        endpoint_t left_bottom;
        endpoint_t left_top;
        endpoint_t right_bottom;
        endpoint_t right_top;
    } saber_snap_t;

    localparam int SNAP_W = $bits(saber_snap_t);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a combinational grant.
// On contention, the requester that was not served last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/saber_history_ctrl.sv
// Ring buffer of saber snapshots, sampled every SAMPLE_PERIOD game ticks.
// A single read port is shared between the trail renderer and the collision checker.
module saber_history_ctrl
    import saber_pkg::*;
#(
    parameter  int DEPTH         = 8,
    parameter  int SAMPLE_PERIOD = 11,
    localparam int AGE_W         = $clog2(DEPTH)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [17:0]         curr_time,
    input  logic                sample_en,
    input  logic [SNAP_W-1:0]   snap_in,
    input  logic [1:0]          req_valid,
    input  logic [2*AGE_W-1:0]  req_age,
    output logic [1:0]          req_ready,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic                rsp_hit,
    output logic [SNAP_W-1:0]   rsp_data,
    output logic [AGE_W:0]      fill_count,
    output logic                sample_pulse
);

    localparam int               CNT_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [AGE_W:0]   FILL_MAX = (AGE_W + 1)'(DEPTH);

    logic [17:0]       last_time_q, last_time_d;
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [AGE_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AGE_W:0]    fill_q, fill_d;
    logic              last_grant_q, last_grant_d;
    logic              sample_pulse_q, sample_pulse_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [SNAP_W-1:0] rsp_data_q, rsp_data_d;
    logic [SNAP_W-1:0] mem_q [DEPTH];

    logic              tick;
    logic              wr_en;
    logic [1:0]        grant;
    logic [AGE_W-1:0]  rd_age;
    logic [AGE_W-1:0]  rd_idx;
    logic              rd_hit;

    rr_arbiter2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        tick           = (curr_time != last_time_q);
        wr_en          = tick && (tick_cnt_q == '0) && sample_en;
        last_time_d    = curr_time;
        tick_cnt_d     = tick_cnt_q;
        wr_ptr_d       = wr_ptr_q;
        fill_d         = fill_q;
        sample_pulse_d = wr_en;

        // The phase counter runs on every tick, even while paused, so pauses keep the sample phase.
        if (tick) begin
            tick_cnt_d = (tick_cnt_q == CNT_LAST) ? '0 : tick_cnt_q + CNT_W'(1);
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AGE_W'(1);
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + (AGE_W + 1)'(1);
            end
        end
    end

    // Reads see the pre-write pointer, fill and array, so a same-cycle write stays invisible.
    always_comb begin
        req_ready    = rst_in ? 2'b00 : grant;
        rd_age       = req_ready[1] ? req_age[AGE_W +: AGE_W] : req_age[0 +: AGE_W];
        rd_idx       = wr_ptr_q - AGE_W'(1) - rd_age;
        rd_hit       = ({1'b0, rd_age} < fill_q);
        last_grant_d = last_grant_q;
        rsp_valid_d  = |req_ready;
        rsp_id_d     = rsp_id_q;
        rsp_hit_d    = rsp_hit_q;
        rsp_data_d   = rsp_data_q;

        if (|req_ready) begin
            last_grant_d = req_ready[1];
            rsp_id_d     = req_ready[1];
            rsp_hit_d    = rd_hit;
            rsp_data_d   = rd_hit ? mem_q[rd_idx] : '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_time_q    <= '0;
            tick_cnt_q     <= '0;
            wr_ptr_q       <= '0;
            fill_q         <= '0;
            last_grant_q   <= 1'b1;
            sample_pulse_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_hit_q      <= 1'b0;
            rsp_data_q     <= '0;
        end else begin
            last_time_q    <= last_time_d;
            tick_cnt_q     <= tick_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            fill_q         <= fill_d;
            last_grant_q   <= last_grant_d;
            sample_pulse_q <= sample_pulse_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_hit_q      <= rsp_hit_d;
            rsp_data_q     <= rsp_data_d;
        end
    end

    // NOTE: the snapshot array has no reset; fill_count gates every read, so stale slots are never returned.
    always_ff @(posedge clk_in) begin
        if (wr_en && !rst_in) begin
            mem_q[wr_ptr_q] <= snap_in;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_hit      = rsp_hit_q;
    assign rsp_data     = rsp_data_q;
    assign fill_count   = fill_q;
    assign sample_pulse = sample_pulse_q;

endmodule

// File: tb/tb_saber_history_ctrl.sv
// Self-checking bench for saber_history_ctrl.
// Directed scenarios plus a randomized run, all checked against a queue-based history model.
module tb_saber_history_ctrl;
    import saber_pkg::*;

    localparam int DEPTH = 8;
    localparam int SP    = 11;
    localparam int AW    = 3;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [17:0]       curr_time;
    logic              sample_en;
    logic [SNAP_W-1:0] snap_in;
    logic [1:0]        req_valid;
    logic [2*AW-1:0]   req_age;
    logic [1:0]        req_ready;
    logic              rsp_valid;
    logic              rsp_id;
    logic              rsp_hit;
    logic [SNAP_W-1:0] rsp_data;
    logic [AW:0]       fill_count;
    logic              sample_pulse;

    saber_history_ctrl dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .curr_time    (curr_time),
        .sample_en    (sample_en),
        .snap_in      (snap_in),
        .req_valid    (req_valid),
        .req_age      (req_age),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_hit      (rsp_hit),
        .rsp_data     (rsp_data),
        .fill_count   (fill_count),
        .sample_pulse (sample_pulse)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: newest snapshot at the front, ticks counted since reset.
    saber_snap_t hist[$];
    int          ticks_seen;
    logic [17:0] m_time;
    logic        m_last_grant;

    logic [1:0]  exp_ready, obs_ready;
    logic        exp_valid, exp_id, exp_hit, exp_pulse;
    saber_snap_t exp_data;
    int          exp_fill;
    int          checks, errors;

    function automatic saber_snap_t rand_snap();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return saber_snap_t'(r[SNAP_W-1:0]);
    endfunction

    task automatic do_reset();
        @(negedge clk_in);
        rst_in    = 1'b1;
        req_valid = 2'b00;
        curr_time = 18'd0;
        sample_en = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        hist.delete();
        ticks_seen   = 0;
        m_time       = 18'd0;
        m_last_grant = 1'b1;
        exp_id       = 1'b0;
        exp_data     = '0;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    // Apply one cycle of stimulus, predict the results, and return after the clock edge.
    task automatic drive_cycle(input logic [17:0] t, input logic en, input saber_snap_t s,
                               input logic [1:0] rv, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        int age;
        @(negedge clk_in);
        curr_time = t;
        sample_en = en;
        snap_in   = s;
        req_valid = rv;
        req_age   = {a1, a0};
        #1;
        obs_ready = req_ready;
        case (rv)
            2'b01:   exp_ready = 2'b01;
            2'b10:   exp_ready = 2'b10;
            2'b11:   exp_ready = m_last_grant ? 2'b01 : 2'b10;
            default: exp_ready = 2'b00;
        endcase
        exp_valid = (exp_ready != 2'b00);
        if (exp_valid) begin
            m_last_grant = exp_ready[1];
            exp_id       = exp_ready[1];
            age          = exp_ready[1] ? int'(a1) : int'(a0);
            exp_hit      = (age < hist.size());
            if (exp_hit) exp_data = hist[age];
            else         exp_data = '0;
        end
        exp_pulse = 1'b0;
        if (t != m_time) begin
            if ((ticks_seen % SP) == 0 && en) begin
                hist.push_front(s);
                if (hist.size() > DEPTH) void'(hist.pop_back());
                exp_pulse = 1'b1;
            end
            ticks_seen++;
        end
        m_time   = t;
        exp_fill = hist.size();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rsp_valid !== 1'b0)    begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (sample_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", sample_pulse); end
        checks++; if (fill_count !== 4'd0)   begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_count); end
        checks++; if (rsp_data !== '0)       begin errors++; $display("FAIL reset_data: got %h want 0", rsp_data); end
        checks++; if (rsp_id !== 1'b0 || rsp_hit !== 1'b0) begin errors++; $display("FAIL reset_id_hit: got %b%b want 00", rsp_id, rsp_hit); end
        checks++; if (req_ready !== 2'b00)   begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    endtask

    task automatic test_first_sample();
        saber_snap_t s, got;
        s = '0;
        s.left_top.x = 12'd100;
        drive_cycle(18'd1, 1'b1, s, 2'b00, '0, '0);
        checks++; if (sample_pulse !== 1'b1) begin errors++; $display("FAIL first_pulse: got %b want 1", sample_pulse); end
        checks++; if (fill_count !== 4'd1)   begin errors++; $display("FAIL first_fill: got %0d want 1", fill_count); end
        drive_cycle(18'd1, 1'b1, rand_snap(), 2'b01, 3'd0, 3'd0);
        got = saber_snap_t'(rsp_data);
        checks++; if (obs_ready !== 2'b01)   begin errors++; $display("FAIL first_ready: got %b want 01", obs_ready); end
        checks++; if (sample_pulse !== 1'b0) begin errors++; $display("FAIL first_pulse_drop: got %b want 0", sample_pulse); end
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_hit !== 1'b1) begin
            errors++; $display("FAIL first_rsp: got v%b id%b hit%b want v1 id0 hit1", rsp_valid, rsp_id, rsp_hit); end
        checks++; if (got.left_top.x !== 12'd100 || rsp_data !== s) begin
            errors++; $display("FAIL first_data: got %h want %h", rsp_data, s); end
    endtask

    task automatic test_sample_period();
        saber_snap_t snaps[24];
        logic        want;
        do_reset();
        for (int k = 1; k <= 23; k++) begin
            snaps[k] = rand_snap();
            drive_cycle(18'(k), 1'b1, snaps[k], 2'b00, '0, '0);
            want = (k == 1 || k == 12 || k == 23);
            checks++; if (sample_pulse !== want) begin errors++; $display("FAIL period_pulse tick %0d: got %b want %b", k, sample_pulse, want); end
        end
        checks++; if (fill_count !== 4'd3) begin errors++; $display("FAIL period_fill: got %0d want 3", fill_count); end
        drive_cycle(18'd23, 1'b1, rand_snap(), 2'b01, 3'd2, 3'd0);
        checks++; if (rsp_hit !== 1'b1 || rsp_data !== snaps[1]) begin
            errors++; $display("FAIL period_age2: got hit%b %h want hit1 %h", rsp_hit, rsp_data, snaps[1]); end
        drive_cycle(18'd23, 1'b1, rand_snap(), 2'b10, 3'd0, 3'd5);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_hit !== 1'b0 || rsp_data !== '0) begin
            errors++; $display("FAIL period_age5_miss: got v%b id%b hit%b %h want v1 id1 hit0 0", rsp_valid, rsp_id, rsp_hit, rsp_data); end
    endtask

    // 20 samples through an 8-slot ring while curr_time crosses the 18-bit wrap.
    task automatic test_wrap();
        saber_snap_t samples[$];
        saber_snap_t s;
        logic [17:0] t;
        int          bad;
        do_reset();
        t   = 18'h3FF00;
        bad = 0;
        for (int k = 1; k <= 1 + 19 * SP; k++) begin
            s = rand_snap();
            if ((k - 1) % SP == 0) samples.push_back(s);
            drive_cycle(t, 1'b1, s, 2'b00, '0, '0);
            checks++; if (sample_pulse !== exp_pulse) begin errors++; $display("FAIL wrap_pulse tick %0d: got %b want %b", k, sample_pulse, exp_pulse); end
            if (t >= 18'h3FFF8 || t < 18'd8) t = t + 18'd1;
            else                              t = t + 18'($urandom_range(1, 9));
        end
        checks++; if (fill_count !== 4'd8 || samples.size() != 20) begin
            errors++; $display("FAIL wrap_fill: got %0d want 8", fill_count); end
        drive_cycle(m_time, 1'b1, rand_snap(), 2'b01, 3'd0, 3'd0);
        checks++; if (rsp_data !== samples[19]) begin errors++; $display("FAIL wrap_age0: got %h want %h", rsp_data, samples[19]); end
        drive_cycle(m_time, 1'b1, rand_snap(), 2'b10, 3'd0, 3'd7);
        checks++; if (rsp_hit !== 1'b1 || rsp_data !== samples[12]) begin
            errors++; $display("FAIL wrap_age7: got hit%b %h want hit1 %h", rsp_hit, rsp_data, samples[12]); end
    endtask

    task automatic test_round_robin();
        logic [1:0] want[4];
        want = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(18'd0, 1'b1, rand_snap(), 2'b11, 3'd0, 3'd0);
            checks++; if (obs_ready !== want[i]) begin errors++; $display("FAIL rr_grant %0d: got %b want %b", i, obs_ready, want[i]); end
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== want[i][1] || rsp_hit !== 1'b0) begin
                errors++; $display("FAIL rr_rsp %0d: got v%b id%b hit%b want v1 id%b hit0", i, rsp_valid, rsp_id, rsp_hit, want[i][1]); end
        end
        drive_cycle(18'd0, 1'b1, rand_snap(), 2'b10, 3'd0, 3'd0);
        checks++; if (obs_ready !== 2'b10) begin errors++; $display("FAIL rr_single: got %b want 10", obs_ready); end
        drive_cycle(18'd0, 1'b1, rand_snap(), 2'b00, 3'd0, 3'd0);
        checks++; if (obs_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_id !== 1'b1) begin
            errors++; $display("FAIL rr_idle: got ready%b v%b id%b want ready00 v0 id1", obs_ready, rsp_valid, rsp_id); end
    endtask

    // A read of age 0 in the write cycle returns the previous newest; the next cycle returns the new snapshot.
    task automatic test_collision();
        saber_snap_t a, b;
        a = rand_snap();
        b = rand_snap();
        drive_cycle(18'd1, 1'b1, a, 2'b00, '0, '0);
        for (int k = 2; k <= 11; k++) drive_cycle(18'(k), 1'b1, rand_snap(), 2'b00, '0, '0);
        drive_cycle(18'd12, 1'b1, b, 2'b01, 3'd0, 3'd0);
        checks++; if (sample_pulse !== 1'b1 || fill_count !== 4'd2) begin
            errors++; $display("FAIL coll_write: got pulse%b fill%0d want pulse1 fill2", sample_pulse, fill_count); end
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== a) begin errors++; $display("FAIL coll_old: got %h want %h", rsp_data, a); end
        drive_cycle(18'd12, 1'b1, rand_snap(), 2'b01, 3'd0, 3'd0);
        checks++; if (rsp_data !== b) begin errors++; $display("FAIL coll_new: got %h want %h", rsp_data, b); end
    endtask

    // Sample points are ticks 1, 12, 23, 34: pausing across tick 23 skips it, and 34 still samples.
    task automatic test_pause();
        int pulses;
        pulses = 0;
        for (int k = 13; k <= 23; k++) begin
            drive_cycle(18'(k), 1'b0, rand_snap(), 2'b00, '0, '0);
            if (sample_pulse === 1'b1) pulses++;
        end
        checks++; if (pulses != 0 || fill_count !== 4'd2) begin
            errors++; $display("FAIL pause_nowrite: got pulses%0d fill%0d want 0 2", pulses, fill_count); end
        for (int k = 24; k <= 34; k++) begin
            drive_cycle(18'(k), 1'b1, rand_snap(), 2'b00, '0, '0);
            checks++; if (sample_pulse !== (k == 34)) begin errors++; $display("FAIL pause_phase tick %0d: got %b want %b", k, sample_pulse, k == 34); end
        end
        checks++; if (fill_count !== 4'd3) begin errors++; $display("FAIL pause_fill: got %0d want 3", fill_count); end
    endtask

    task automatic test_random();
        logic [1:0]    pend;
        logic [AW-1:0] page[2];
        logic [17:0]   t;
        logic          en;
        pend = 2'b00;
        page = '{3'd0, 3'd0};
        t    = m_time;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 4) begin
                    pend[i] = 1'b1;
                    page[i] = AW'($urandom_range(0, DEPTH - 1));
                end
            end
            if ($urandom_range(0, 1) == 1) t = t + 18'($urandom_range(1, 40));
            en = ($urandom_range(0, 9) != 0);
            drive_cycle(t, en, rand_snap(), pend, page[0], page[1]);
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready %0d: got %b want %b", n, obs_ready, exp_ready); end
            checks++; if (rsp_valid !== exp_valid || sample_pulse !== exp_pulse || fill_count !== exp_fill) begin
                errors++; $display("FAIL rnd_status %0d: got v%b p%b f%0d want v%b p%b f%0d",
                                   n, rsp_valid, sample_pulse, fill_count, exp_valid, exp_pulse, exp_fill); end
            checks++; if (rsp_id !== exp_id || rsp_data !== exp_data || (exp_valid && rsp_hit !== exp_hit)) begin
                errors++; $display("FAIL rnd_rsp %0d: got id%b hit%b %h want id%b hit%b %h",
                                   n, rsp_id, rsp_hit, rsp_data, exp_id, exp_hit, exp_data); end
            pend = pend & ~obs_ready;
        end
    endtask

    task automatic test_reset_midop();
        drive_cycle(m_time + 18'd1, 1'b1, rand_snap(), 2'b00, '0, '0);
        @(negedge clk_in);
        rst_in    = 1'b1;
        req_valid = 2'b01;
        req_age   = '0;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL midrst_ready: got %b want 00", req_ready); end
        @(posedge clk_in);
        #1;
        checks++; if (rsp_valid !== 1'b0 || fill_count !== 4'd0 || sample_pulse !== 1'b0) begin
            errors++; $display("FAIL midrst_state: got v%b f%0d p%b want v0 f0 p0", rsp_valid, fill_count, sample_pulse); end
        do_reset();
        drive_cycle(18'd1, 1'b1, rand_snap(), 2'b01, 3'd0, 3'd0);
        checks++; if (rsp_hit !== 1'b0 || sample_pulse !== 1'b1 || fill_count !== 4'd1) begin
            errors++; $display("FAIL midrst_refill: got hit%b p%b f%0d want hit0 p1 f1", rsp_hit, sample_pulse, fill_count); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_in    = 1'b1;
        curr_time = 18'd0;
        sample_en = 1'b1;
        snap_in   = '0;
        req_valid = 2'b00;
        req_age   = '0;
        test_reset();
        test_first_sample();
        test_sample_period();
        test_wrap();
        test_round_robin();
        test_collision();
        test_pause();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
